// File: rtl/pio_pkg.sv
// Shared definitions for the debounced PIO block.
// Holds the Avalon-MM register word offsets, the fixed read latency and a
// helper that sizes the per-channel debounce counter.
package pio_pkg;

  // Register word offsets (avs_address); offsets 6 and 7 are unmapped.
  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_IRQ_MASK = 3'd1;
  localparam logic [2:0] REG_EDGE_CAP = 3'd2;
  localparam logic [2:0] REG_RISE_EN  = 3'd3;
  localparam logic [2:0] REG_FALL_EN  = 3'd4;
  localparam logic [2:0] REG_RAW      = 3'd5;

  // avs_readdata is valid this many cycles after avs_read.
  localparam int unsigned READ_LATENCY = 32'd1;

  // Counter width able to hold 0..cycles without wrapping. The bypass case
  // (cycles == 0) still gets a 1-bit width so no zero-width vector appears.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    if (cycles == 32'd0) begin
      return 32'd1;
    end else begin
      return $clog2(cycles + 32'd1);
    end
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounce channel: 2-flop synchronizer, stability counter and the
// accepted (debounced) level.
// Ports:
//   clk, reset_n  system clock, asynchronous active-low reset
//   raw_in        raw asynchronous input
//   synced        synchronizer output (second flop)
//   state         debounced level, resets to RESET_VALUE
module debounce_bit
  import pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic synced,
  output logic state
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

  logic sync1_r;
  logic sync2_r;
  logic state_r;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: accepted level is the synced level one cycle later.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_r <= RESET_VALUE;
        end else begin
          state_r <= sync2_r;
        end
      end
    end else begin : g_count
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt_r;

      // Count consecutive cycles the synced level disagrees with the
      // accepted level; accept on the last count. Any agreement restarts
      // the count, so a bounce discards partial progress.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_r   <= {CW{1'b0}};
          state_r <= RESET_VALUE;
        end else if (sync2_r != state_r) begin
          if (cnt_r == LAST) begin
            state_r <= sync2_r;
            cnt_r   <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end else begin
          cnt_r <= {CW{1'b0}};
        end
      end
    end
  endgenerate

  assign synced = sync2_r;
  assign state  = state_r;

endmodule

// File: rtl/debounced_pio.sv
// Debounced parallel input port with an Avalon-MM slave register file,
// per-channel rise/fall edge capture and a level interrupt.
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   in_port[WIDTH]         raw asynchronous inputs
//   avs_address[3]         register word address
//   avs_read, avs_write    access strobes
//   avs_writedata[32]      write data
//   avs_readdata[32]       read data, valid one cycle after avs_read
//   irq                    registered |(EDGE_CAP & IRQ_MASK)
module debounced_pio
  import pio_pkg::*;
#(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  logic [WIDTH-1:0] synced_s;
  logic [WIDTH-1:0] data_s;
  logic [WIDTH-1:0] data_prev_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] edge_cap_next_s;
  logic [WIDTH-1:0] wdata_s;
  logic [31:0]      rd_mux_s;
  logic [31:0]      readdata_r;
  logic             irq_r;
  logic             unused_wdata_s;

  // Zero-extend a channel vector to the 32-bit bus.
  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r          = 32'd0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_chan
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[i])
      ) u_debounce_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .raw_in  (in_port[i]),
        .synced  (synced_s[i]),
        .state   (data_s[i])
      );
    end
  endgenerate

  assign wdata_s        = avs_writedata[WIDTH-1:0];
  assign unused_wdata_s = ^avs_writedata;

  // Edge detection against last cycle's debounced level, and EDGE_CAP next
  // state: a new edge overrides a write-1-clear on the same bit.
  always_comb begin
    rise_s = data_s & ~data_prev_r;
    fall_s = ~data_s & data_prev_r;
    if (avs_write && (avs_address == REG_EDGE_CAP)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    edge_cap_next_s = (edge_cap_r & ~clr_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
  end

  // Read multiplexer; unmapped offsets return zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      REG_DATA:     rd_mux_s = zext(data_s);
      REG_IRQ_MASK: rd_mux_s = zext(irq_mask_r);
      REG_EDGE_CAP: rd_mux_s = zext(edge_cap_r);
      REG_RISE_EN:  rd_mux_s = zext(rise_en_r);
      REG_FALL_EN:  rd_mux_s = zext(fall_en_r);
      REG_RAW:      rd_mux_s = zext(synced_s);
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Control registers written from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_r <= {WIDTH{1'b0}};
      rise_en_r  <= {WIDTH{1'b0}};
      fall_en_r  <= {WIDTH{1'b0}};
    end else if (avs_write) begin
      case (avs_address)
        REG_IRQ_MASK: irq_mask_r <= wdata_s;
        REG_RISE_EN:  rise_en_r  <= wdata_s;
        REG_FALL_EN:  fall_en_r  <= wdata_s;
        default:      ;
      endcase
    end
  end

  // Edge history and capture. data_prev_r resets to the same level as the
  // debounced state so reset itself never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_prev_r <= RESET_VALUE;
      edge_cap_r  <= {WIDTH{1'b0}};
    end else begin
      data_prev_r <= data_s;
      edge_cap_r  <= edge_cap_next_s;
    end
  end

  // Registered read data (captures pre-write values) and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      if (avs_read) begin
        readdata_r <= rd_mux_s;
      end
      irq_r <= |(edge_cap_r & irq_mask_r);
    end
  end

  assign avs_readdata = readdata_r;
  assign irq          = irq_r;

endmodule
